// File: rtl/cache_fill_fsm.sv
// Block-fill miss handler: on a cache miss, issues back-to-back word reads for the whole block,
// streams returned words into the data array and writes the tag with the last word.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  localparam int WB         = $clog2(BLOCK_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [WB-1:0]         fill_word,
  output logic [15:0]           fill_data,
  output logic                  o_dbg_state
);

  localparam int OFF = WB + 1;
  localparam int CW  = WB + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_recv_cnt;
  logic                  w_unused;

  // Byte-offset bits of the miss address are dropped; the fill always starts at word 0.
  assign w_unused    = ^miss_address[OFF-1:0];
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (miss_detected) begin
            r_base      <= {miss_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
        end
        FILL: begin
          if (mem_enable)       r_issue_cnt <= r_issue_cnt + CW'(1);
          if (write_data_array) r_recv_cnt  <= r_recv_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Issue and receive sides run independently, so the last request and the
  // first return may land in the same cycle.
  always_comb begin
    w_state_next     = r_state;
    mem_enable       = 1'b0;
    mem_addr         = '0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    case (r_state)
      IDLE: begin
        if (miss_detected) w_state_next = FILL;
      end
      FILL: begin
        fsm_busy   = 1'b1;
        mem_enable = (r_issue_cnt < CW'(BLOCK_WORDS));
        mem_addr   = r_base | {{(ADDR_WIDTH-OFF){1'b0}}, r_issue_cnt[WB-1:0], 1'b0};
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = r_recv_cnt[WB-1:0];
          fill_data        = memory_data;
          if (r_recv_cnt == CW'(BLOCK_WORDS - 1)) begin
            write_tag_array = 1'b1;
            w_state_next    = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: directed misses, a latency-4 memory model with optional return gaps,
// and a monitor that pops expected requests, writes, tag writes and busy lengths.
module tb_cache_fill_fsm;

  localparam int L  = 4;
  localparam int WW = 3 + 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        mem_enable;
  logic [15:0] mem_addr;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        o_dbg_state;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
    .clk(clk),
    .rst(rst),
    .miss_detected(miss_detected),
    .miss_address(miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data(memory_data),
    .mem_enable(mem_enable),
    .mem_addr(mem_addr),
    .fsm_busy(fsm_busy),
    .write_data_array(write_data_array),
    .write_tag_array(write_tag_array),
    .fill_word(fill_word),
    .fill_data(fill_data),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard queues ----------------
  logic [15:0] exp_q[$];
  logic [WW-1:0] exp_wr_q[$];
  logic [3:0]  exp_tag_q[$];
  int          exp_busy_q[$];

  // ---------------- memory model controls ----------------
  int flush_req = 0;
  int flush_done = 0;
  int stray_req = 0;
  int stray_done = 0;
  int ret_limit = -1;
  bit gap_en = 1'b0;
  bit done = 1'b0;
  bit gap_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  logic [15:0] pend_addr[$];
  int          pend_due[$];
  int          ret_cnt = 0;
  int          gap_idx = 0;

  // Memory: each request returns L cycles later, in order, data = addr ^ 16'h5A5A.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      memory_data_valid = 1'b0;
      memory_data       = '0;
      if (pend_addr.size() == 0) begin
        gap_idx = 0;
        ret_cnt = 0;
      end
      if (flush_done != flush_req) begin
        pend_addr.delete();
        pend_due.delete();
        ret_cnt    = 0;
        flush_done = flush_req;
      end else if (stray_done != stray_req) begin
        memory_data_valid = 1'b1;
        memory_data       = 16'hBEEF;
        stray_done        = stray_done + 1;
      end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        if (ret_limit < 0 || ret_cnt < ret_limit) begin
          if (!gap_en || gap_pat[gap_idx % 7]) begin
            memory_data_valid = 1'b1;
            memory_data       = pend_addr[0] ^ 16'h5A5A;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            ret_cnt = ret_cnt + 1;
          end
          gap_idx = gap_idx + 1;
        end
      end
      @(negedge clk);
      if (mem_enable) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + L);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_fill(input logic [15:0] a, input int nwr, input int busy_len, input bit tag);
    logic [15:0] b;
    logic [15:0] w;
    b = {a[15:4], 4'h0};
    for (int i = 0; i < 8; i++) exp_q.push_back(b | 16'(i * 2));
    for (int i = 0; i < nwr; i++) begin
      w = (b | 16'(i * 2)) ^ 16'h5A5A;
      exp_wr_q.push_back({3'(i), w});
    end
    if (tag) exp_tag_q.push_back({1'b1, 3'd7});
    exp_busy_q.push_back(busy_len);
  endtask

  task automatic issue_miss(input logic [15:0] a);
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = a;
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fsm_busy == lvl) break;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with miss and valid toggling.
    rst       = 1'b1;
    stray_req = 2;
    repeat (2) begin
      @(posedge clk);
      #1;
      miss_detected = ~miss_detected;
      miss_address  = 16'h1236;
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    miss_detected = 1'b0;
    repeat (2) @(posedge clk);

    // Plain fill, latency 4, no gaps.
    push_fill(16'h1236, 8, 12, 1'b1);
    issue_miss(16'h1236);
    wait_busy(1'b0);

    // Top of address space: no wrap to 0x0000.
    push_fill(16'hFFFE, 8, 12, 1'b1);
    issue_miss(16'hFFFE);
    wait_busy(1'b0);

    // Returns with gaps 1,0,0,1,1,0,1,...: last word 17 cycles after request 0.
    gap_en = 1'b1;
    push_fill(16'h2468, 8, 18, 1'b1);
    issue_miss(16'h2468);
    wait_busy(1'b0);
    gap_en = 1'b0;

    // Reset after 3 returns, then stray valids, then a fresh fill.
    ret_limit = 3;
    push_fill(16'h0040, 3, 9, 1'b0);
    issue_miss(16'h0040);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    flush_req = flush_req + 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (flush_done == flush_req) break;
    end
    ret_limit = -1;
    stray_req = stray_req + 2;
    repeat (4) @(posedge clk);
    push_fill(16'h0080, 8, 12, 1'b1);
    issue_miss(16'h0080);
    wait_busy(1'b0);

    // Miss held high with a new address during the fill.
    push_fill(16'h1236, 8, 12, 1'b1);
    push_fill(16'h5000, 8, 12, 1'b1);
    @(posedge clk);
    #1;
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    @(posedge clk);
    #1;
    miss_address = 16'h5000;
    wait_busy(1'b0);
    wait_busy(1'b1);
    @(posedge clk);
    #1;
    miss_detected = 1'b0;
    wait_busy(1'b0);

    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int run_len = 0;
  int wd = 0;
  logic [15:0]   e_addr;
  logic [WW-1:0] e_wr;
  logic [3:0]    e_tag;
  int            e_busy;

  always @(negedge clk) begin
    wd = wd + 1;
    if (wd > 5000) begin
      errors = errors + 1;
      $display("FAIL watchdog: got %0d cycles, required fewer than 5000", wd);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else if (done) begin
      checks = checks + 4;
      if (exp_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover_req: got %0d pending, required 0", exp_q.size());
      end
      if (exp_wr_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover_wr: got %0d pending, required 0", exp_wr_q.size());
      end
      if (exp_tag_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover_tag: got %0d pending, required 0", exp_tag_q.size());
      end
      if (exp_busy_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover_busy: got %0d pending, required 0", exp_busy_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      if (!fsm_busy) begin
        checks = checks + 1;
        if (mem_enable || write_data_array || write_tag_array ||
            mem_addr != '0 || fill_word != '0 || fill_data != '0) begin
          errors = errors + 1;
          $display("FAIL idle_outputs: got en=%b addr=%h wd=%b wt=%b fw=%0d fd=%h, required all 0",
                   mem_enable, mem_addr, write_data_array, write_tag_array, fill_word, fill_data);
        end
      end
      if (mem_enable) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL req_addr: got request %h, required none", mem_addr);
        end else begin
          e_addr = exp_q.pop_front();
          if (mem_addr !== e_addr) begin
            errors = errors + 1;
            $display("FAIL req_addr: got %h, required %h", mem_addr, e_addr);
          end
        end
      end
      if (write_data_array) begin
        checks = checks + 1;
        if (exp_wr_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL data_write: got word %0d data %h, required no write", fill_word, fill_data);
        end else begin
          e_wr = exp_wr_q.pop_front();
          if ({fill_word, fill_data} !== e_wr) begin
            errors = errors + 1;
            $display("FAIL data_write: got word %0d data %h, required word %0d data %h",
                     fill_word, fill_data, e_wr[18:16], e_wr[15:0]);
          end
        end
      end
      if (write_tag_array) begin
        checks = checks + 1;
        if (exp_tag_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL tag_write: got tag write, required none");
        end else begin
          e_tag = exp_tag_q.pop_front();
          if ({write_data_array, fill_word} !== e_tag) begin
            errors = errors + 1;
            $display("FAIL tag_write: got wd=%b word=%0d, required wd=%b word=%0d",
                     write_data_array, fill_word, e_tag[3], e_tag[2:0]);
          end
        end
      end
      if (fsm_busy) begin
        run_len = run_len + 1;
      end else if (run_len > 0) begin
        checks = checks + 1;
        if (exp_busy_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL busy_len: got %0d cycles, required no busy period", run_len);
        end else begin
          e_busy = exp_busy_q.pop_front();
          if (run_len != e_busy) begin
            errors = errors + 1;
            $display("FAIL busy_len: got %0d cycles, required %0d", run_len, e_busy);
          end
        end
        run_len = 0;
      end
    end
  end

endmodule
